// File: rtl/ray_dispatcher_pkg.sv
// Shared types for the ray dispatcher front end.
// Tag field width follows the codebase TAG_SIZE macro.
`ifndef TAG_SIZE
`define TAG_SIZE 6
`endif

package ray_dispatcher_pkg;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } RayDirection;

  typedef struct packed {
    logic [`TAG_SIZE-1:0] tag;
    RayDirection          dir;
  } TaggedRay;

  typedef enum logic {
    RUN,
    DRAIN
  } disp_state_e;

endpackage

// File: rtl/ray_dispatcher_if.sv
// Upstream ray handshake and divider-lane bus.
// slave is the dispatcher side, master the driver side.
interface ray_dispatcher_if #(
  parameter int DIV_COUNT = 16
);
  import ray_dispatcher_pkg::*;

  logic                 ray_valid_in;
  RayDirection          ray_dir_in;
  logic                 ray_ready_out;
  logic [DIV_COUNT-1:0] div_busy_in;
  logic [DIV_COUNT-1:0] fifo_overflow_in;
  logic [DIV_COUNT-1:0] div_start_out;
  TaggedRay             tagged_ray_out;

  modport slave (
    input  ray_valid_in,
    input  ray_dir_in,
    input  div_busy_in,
    input  fifo_overflow_in,
    output ray_ready_out,
    output div_start_out,
    output tagged_ray_out
  );

  modport master (
    output ray_valid_in,
    output ray_dir_in,
    output div_busy_in,
    output fifo_overflow_in,
    input  ray_ready_out,
    input  div_start_out,
    input  tagged_ray_out
  );
endinterface

// File: rtl/ray_dispatcher_rr_arbiter.sv
// Combinational round-robin arbiter.
// First request at or after ptr, scanning cyclically.
module rr_arbiter #(
  parameter int N = 16,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = |req;
    // Scan downward so the closest request wins.
    for (int k = N - 1; k >= 0; k--) begin
      automatic int j = (int'(ptr) + k) % N;
      if (req[W'(j)]) idx = W'(j);
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/ray_dispatcher.sv
// Ray dispatcher: tags in-order rays and issues them
// round-robin to free divider lanes under a credit limit.
module ray_dispatcher
  import ray_dispatcher_pkg::*;
#(
  parameter int DIV_COUNT    = 16,
  parameter int TAG_SIZE     = `TAG_SIZE,
  parameter int MAX_INFLIGHT = 32
) (
  input  logic clk,
  input  logic reset,
  ray_dispatcher_if.slave bus,
  input  logic retire_in,
  input  logic flush_in,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_out,
  output logic flush_done_out
);

  localparam int LW = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam int TW = `TAG_SIZE;

  disp_state_e state, state_n;

  logic                 live;
  logic                 pending_valid;
  RayDirection          pending_dir;
  RayDirection          issue_dir;
  logic [TAG_SIZE-1:0]  tag;
  logic [LW-1:0]        rr_ptr;
  logic [LW-1:0]        last_lane;
  logic [LW-1:0]        sel;
  logic                 issued_q;
  logic [CW-1:0]        inflight;
  logic [DIV_COUNT-1:0] eligible;
  logic [DIV_COUNT-1:0] grant;
  logic [DIV_COUNT-1:0] start_q;
  TaggedRay             tagged_q;
  logic                 any_elig;
  logic                 can_issue;
  logic                 accept;
  logic                 issue;
  logic                 retire_ok;
  logic                 drain_done;

  // Mask the lane started last cycle; its busy flag lags by one.
  always_comb begin
    for (int i = 0; i < DIV_COUNT; i++) begin
      eligible[i] = !bus.div_busy_in[i] &&
                    !bus.fifo_overflow_in[i] &&
                    !(issued_q && last_lane == LW'(i));
    end
  end

  rr_arbiter #(.N(DIV_COUNT)) u_arb (
    .req   (eligible),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (sel),
    .any   (any_elig)
  );

  assign can_issue = any_elig &&
                     (inflight < CW'(MAX_INFLIGHT));
  assign bus.ray_ready_out = live && state == RUN &&
                             (!pending_valid || can_issue);
  assign accept     = bus.ray_valid_in && bus.ray_ready_out;
  assign issue      = can_issue && (pending_valid || accept);
  assign issue_dir  = pending_valid ? pending_dir
                                    : bus.ray_dir_in;
  assign retire_ok  = retire_in && inflight != '0;
  assign drain_done = !pending_valid && inflight == '0;

  assign bus.div_start_out  = start_q;
  assign bus.tagged_ray_out = tagged_q;
  assign inflight_out       = inflight;

  always_comb begin
    state_n        = state;
    flush_done_out = 1'b0;
    unique case (state)
      RUN: if (flush_in) state_n = DRAIN;
      DRAIN: begin
        if (drain_done) begin
          state_n        = RUN;
          flush_done_out = 1'b1;
        end
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= RUN;
      live          <= 1'b0;
      pending_valid <= 1'b0;
      pending_dir   <= '0;
      tag           <= TAG_SIZE'(1);
      rr_ptr        <= '0;
      last_lane     <= '0;
      issued_q      <= 1'b0;
      inflight      <= '0;
      start_q       <= '0;
      tagged_q      <= '0;
    end else begin
      state    <= state_n;
      live     <= 1'b1;
      issued_q <= issue;
      start_q  <= issue ? grant : '0;
      if (pending_valid) begin
        if (issue) pending_valid <= accept;
      end else begin
        pending_valid <= accept && !issue;
      end
      if (accept) pending_dir <= bus.ray_dir_in;
      if (issue) begin
        tagged_q  <= '{tag: TW'(tag), dir: issue_dir};
        last_lane <= sel;
        rr_ptr    <= (sel == LW'(DIV_COUNT - 1)) ? '0
                                                 : sel + 1'b1;
        // Tag 0 means "none" downstream, so wrap to 1.
        tag       <= (&tag) ? TAG_SIZE'(1) : tag + 1'b1;
      end
      if (state == DRAIN && drain_done) begin
        tag    <= TAG_SIZE'(1);
        rr_ptr <= '0;
      end
      unique case ({issue, retire_ok})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ray_dispatcher.sv
// Scoreboard bench for ray_dispatcher: dut_a uses default
// parameters, dut_b a 4-credit, 3-bit-tag configuration.
module tb_ray_dispatcher;
  import ray_dispatcher_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       retire_a = 1'b0, flush_a = 1'b0;
  logic       retire_b = 1'b0, flush_b = 1'b0;
  logic [5:0] infl_a;
  logic [2:0] infl_b;
  logic       fd_a, fd_b;

  ray_dispatcher_if a_if ();
  ray_dispatcher_if b_if ();

  ray_dispatcher #(
    .DIV_COUNT(16), .TAG_SIZE(`TAG_SIZE), .MAX_INFLIGHT(32)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(a_if.slave),
    .retire_in(retire_a), .flush_in(flush_a),
    .inflight_out(infl_a), .flush_done_out(fd_a)
  );

  ray_dispatcher #(
    .DIV_COUNT(16), .TAG_SIZE(3), .MAX_INFLIGHT(4)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(b_if.slave),
    .retire_in(retire_b), .flush_in(flush_b),
    .inflight_out(infl_b), .flush_done_out(fd_b)
  );

  typedef struct {
    int          lane;
    int          tag;
    logic [15:0] x;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   fd_cnt_a    = 0;

  function automatic RayDirection mk(input logic [15:0] x);
    return '{x: x, y: ~x, z: 16'h1234};
  endfunction

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mon(input int d, input logic [15:0] st,
                     input TaggedRay tr);
    exp_t e;
    if (st == 16'h0) return;
    if ((d == 0 && qa.size() == 0) ||
        (d == 1 && qb.size() == 0)) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_start dut%0d: got %0h expected none",
               d, st);
      return;
    end
    if (d == 0) e = qa.pop_front();
    else        e = qb.pop_front();
    check($sformatf("lane_dut%0d", d), 64'(st), 64'(1) << e.lane);
    check($sformatf("tag_dut%0d", d), 64'(tr.tag), 64'(e.tag));
    check($sformatf("dir_dut%0d", d), 64'(tr.dir), 64'(mk(e.x)));
  endtask

  always @(negedge clk) begin
    mon(0, a_if.div_start_out, a_if.tagged_ray_out);
    mon(1, b_if.div_start_out, b_if.tagged_ray_out);
    if (fd_a === 1'b1) fd_cnt_a++;
  end

  task automatic drive(input int d, input logic v,
                       input logic [15:0] x);
    if (d == 0) begin
      a_if.ray_valid_in = v;
      a_if.ray_dir_in   = mk(x);
    end else begin
      b_if.ray_valid_in = v;
      b_if.ray_dir_in   = mk(x);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic [15:0] x,
                      input int lane, input int tag,
                      input bit push);
    bit   acc;
    exp_t e;
    acc    = 1'b0;
    e.lane = lane;
    e.tag  = tag;
    e.x    = x;
    if (push) begin
      if (d == 0) qa.push_back(e);
      else        qb.push_back(e);
    end
    drive(d, 1'b1, x);
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = (d == 0) ? a_if.ray_ready_out : b_if.ray_ready_out;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout dut%0d: got no accept expected accept",
               d);
    end
  endtask

  task automatic rst_pulse();
    @(posedge clk);
    #2 reset = 1'b1;
    drive(0, 1'b0, 16'h0);
    drive(1, 1'b0, 16'h0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    qa.delete();
    qb.delete();
    step(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    drive(0, 1'b0, 16'h0);
    drive(1, 1'b0, 16'h0);
    a_if.div_busy_in      = '0;
    a_if.fifo_overflow_in = '0;
    b_if.div_busy_in      = '0;
    b_if.fifo_overflow_in = '0;

    #12;
    check("rst_ready", a_if.ray_ready_out, 0);
    check("rst_start", a_if.div_start_out, 0);
    check("rst_tagged", a_if.tagged_ray_out, 0);
    check("rst_inflight", infl_a, 0);
    check("rst_flush_done", fd_a, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    step(1);
    check("ready_after_reset", a_if.ray_ready_out, 1);

    // back-to-back rays
    for (int i = 0; i < 5; i++)
      send(0, 16'h100 + 16'(i), i, i + 1, 1'b1);
    drive(0, 1'b0, 16'h0);
    step(3);
    @(negedge clk);
    check("b2b_inflight", infl_a, 5);
    check("tagged_hold_tag", a_if.tagged_ray_out.tag, 5);
    check("tagged_hold_dir", a_if.tagged_ray_out.dir, mk(16'h104));

    // lane skipping
    rst_pulse();
    a_if.fifo_overflow_in = 16'h0002;
    a_if.div_busy_in      = 16'h0004;
    send(0, 16'h200, 0, 1, 1'b1);
    send(0, 16'h201, 3, 2, 1'b1);
    send(0, 16'h202, 4, 3, 1'b1);
    drive(0, 1'b0, 16'h0);
    a_if.fifo_overflow_in = '0;
    a_if.div_busy_in      = '0;
    step(2);
    @(negedge clk);
    check("skip_inflight", infl_a, 3);
    step(1);
    retire_a = 1'b1;
    step(5);
    retire_a = 1'b0;
    @(negedge clk);
    check("retire_saturate", infl_a, 0);

    // flush with three in flight
    step(1);
    send(0, 16'h300, 5, 4, 1'b1);
    send(0, 16'h301, 6, 5, 1'b1);
    send(0, 16'h302, 7, 6, 1'b1);
    drive(0, 1'b0, 16'h0);
    flush_a = 1'b1;
    step(1);
    flush_a = 1'b0;
    @(negedge clk);
    check("drain_ready_low", a_if.ray_ready_out, 0);
    step(3);
    check("no_early_flush_done", fd_cnt_a, 0);
    retire_a = 1'b1;
    step(3);
    retire_a = 1'b0;
    step(3);
    check("flush_done_once", fd_cnt_a, 1);
    send(0, 16'h303, 0, 1, 1'b1);
    drive(0, 1'b0, 16'h0);
    retire_a = 1'b1;
    step(1);
    retire_a = 1'b0;

    // flush with nothing in flight: one DRAIN cycle
    flush_a = 1'b1;
    step(1);
    flush_a = 1'b0;
    @(negedge clk);
    check("idle_flush_done", fd_a, 1);
    check("idle_flush_ready", a_if.ray_ready_out, 0);
    step(1);
    @(negedge clk);
    check("idle_flush_back", a_if.ray_ready_out, 1);
    check("idle_flush_pulse", fd_a, 0);

    // asynchronous reset mid-stream
    step(1);
    send(0, 16'h400, 0, 1, 1'b1);
    send(0, 16'h401, 1, 2, 1'b1);
    @(posedge clk);
    #2;
    check("pre_reset_start", a_if.div_start_out, 16'h0004);
    #1 reset = 1'b1;
    #1;
    check("async_rst_start", a_if.div_start_out, 0);
    check("async_rst_inflight", infl_a, 0);
    check("async_rst_tagged", a_if.tagged_ray_out, 0);
    drive(0, 1'b0, 16'h0);
    qa.delete();
    step(2);
    #1 reset = 1'b0;
    step(1);
    send(0, 16'h410, 0, 1, 1'b1);
    drive(0, 1'b0, 16'h0);
    step(3);

    // credit limit on dut_b
    for (int i = 0; i < 4; i++)
      send(1, 16'h500 + 16'(i), i, i + 1, 1'b1);
    send(1, 16'h504, 0, 0, 1'b0);
    drive(1, 1'b1, 16'h505);
    @(negedge clk);
    check("credit_ready_low", b_if.ray_ready_out, 0);
    check("credit_inflight", infl_b, 4);
    step(3);
    @(negedge clk);
    check("credit_hold", b_if.ray_ready_out, 0);
    step(1);
    begin
      exp_t e;
      e.lane = 4;
      e.tag  = 5;
      e.x    = 16'h504;
      qb.push_back(e);
    end
    retire_b = 1'b1;
    step(1);
    retire_b = 1'b0;
    step(1);
    @(negedge clk);
    check("credit_release_start", b_if.div_start_out, 16'h0010);
    drive(1, 1'b0, 16'h0);
    step(2);
    @(negedge clk);
    check("credit_refull_ready", b_if.ray_ready_out, 0);
    check("credit_refull_inflight", infl_b, 4);

    // tag wrap with 3-bit tags
    rst_pulse();
    retire_b = 1'b1;
    for (int i = 0; i < 9; i++)
      send(1, 16'h600 + 16'(i), i, (i % 7) + 1, 1'b1);
    drive(1, 1'b0, 16'h0);
    step(3);
    retire_b = 1'b0;
    @(negedge clk);
    check("wrap_inflight", infl_b, 0);

    step(2);
    check("scoreboard_empty", qa.size() + qb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
